// File: rtl/matador_cmd_pkg.sv
// Shared drive-command definitions for the robot transmitter and the base-station receiver.
package matador_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_STOP  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_BACK  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_HORN  = 3'd5
  } cmd_t;

  localparam logic [7:0] ASC_STOP  = 8'h53;  // 'S'
  localparam logic [7:0] ASC_FWD   = 8'h46;  // 'F'
  localparam logic [7:0] ASC_BACK  = 8'h42;  // 'B'
  localparam logic [7:0] ASC_LEFT  = 8'h4C;  // 'L'
  localparam logic [7:0] ASC_RIGHT = 8'h52;  // 'R'
  localparam logic [7:0] ASC_HORN  = 8'h48;  // 'H'

  // Receiver state machine encoding
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Result of decoding one received byte
  typedef struct packed {
    logic valid;
    cmd_t cmd;
  } cmd_dec_t;

  function automatic logic [7:0] cmd_to_ascii(input cmd_t cmd);
    logic [7:0] ascii;
    case (cmd)
      CMD_STOP:  ascii = ASC_STOP;
      CMD_FWD:   ascii = ASC_FWD;
      CMD_BACK:  ascii = ASC_BACK;
      CMD_LEFT:  ascii = ASC_LEFT;
      CMD_RIGHT: ascii = ASC_RIGHT;
      CMD_HORN:  ascii = ASC_HORN;
      default:   ascii = ASC_STOP;
    endcase
    return ascii;
  endfunction

  // Only the exact upper-case characters are commands; anything else is reported invalid.
  function automatic cmd_dec_t ascii_to_cmd(input logic [7:0] ascii);
    cmd_dec_t dec;
    dec.valid = 1'b1;
    dec.cmd   = CMD_STOP;
    case (ascii)
      ASC_STOP:  dec.cmd = CMD_STOP;
      ASC_FWD:   dec.cmd = CMD_FWD;
      ASC_BACK:  dec.cmd = CMD_BACK;
      ASC_LEFT:  dec.cmd = CMD_LEFT;
      ASC_RIGHT: dec.cmd = CMD_RIGHT;
      ASC_HORN:  dec.cmd = CMD_HORN;
      default:   dec.valid = 1'b0;
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: input synchroniser, start-bit qualification, LSB-first
// data capture, stop-bit check and line-break hold-off.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_in,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err
);
  import matador_cmd_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] settle_q, settle_d;
  logic                   armed_q, armed_d;
  logic                   rx_prev_q, rx_prev_d;
  rx_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_byte_q, rx_byte_d;
  logic                   rx_byte_valid_q, rx_byte_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rx_s;

  assign rx_s          = sync_q[SYNC_STAGES-1];
  assign rx_byte       = rx_byte_q;
  assign rx_byte_valid = rx_byte_valid_q;
  assign frame_err     = frame_err_q;

  // Next-state logic; the receiver only arms once the synchroniser has flushed its
  // reset preset and shows a genuinely high line, so a line held low through reset
  // cannot fake a start bit.
  always_comb begin
    sync_d          = {sync_q[SYNC_STAGES-2:0], uart_in};
    settle_d        = {settle_q[SYNC_STAGES-2:0], 1'b1};
    armed_d         = armed_q | (settle_q[SYNC_STAGES-1] & rx_s);
    rx_prev_d       = rx_s;
    state_d         = state_q;
    cnt_d           = cnt_q;
    bit_idx_d       = bit_idx_q;
    shift_d         = shift_q;
    rx_byte_d       = rx_byte_q;
    rx_byte_valid_d = 1'b0;
    frame_err_d     = 1'b0;

    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (armed_q && rx_prev_q && !rx_s) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d             = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_byte_d       = shift_q;
            rx_byte_valid_d = 1'b1;
            state_d         = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_BREAK: begin
        cnt_d = '0;
        if (rx_s) begin
          state_d = RX_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // State register; synchroniser presets to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q          <= '1;
      settle_q        <= '0;
      armed_q         <= 1'b0;
      rx_prev_q       <= 1'b1;
      state_q         <= RX_IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      rx_byte_q       <= '0;
      rx_byte_valid_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      sync_q          <= sync_d;
      settle_q        <= settle_d;
      armed_q         <= armed_d;
      rx_prev_q       <= rx_prev_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      rx_byte_q       <= rx_byte_d;
      rx_byte_valid_q <= rx_byte_valid_d;
      frame_err_q     <= frame_err_d;
    end
  end

endmodule

// File: rtl/uart_cmd_rx.sv
// Drive-command receiver: UART byte reception plus a registered command decode
// presented on a valid/ready handshake where the newest command always wins.
module uart_cmd_rx
  import matador_cmd_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_in,
  output cmd_t       cmd_out,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  output logic       frame_err,
  output logic       unknown_err,
  output logic       overrun_err
);

  logic [7:0] core_byte;
  logic       core_valid;
  cmd_dec_t   dec;
  logic       hit;
  cmd_t       cmd_out_q, cmd_out_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       unknown_err_q, unknown_err_d;
  logic       overrun_err_q, overrun_err_d;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_in      (uart_in),
    .rx_byte      (core_byte),
    .rx_byte_valid(core_valid),
    .frame_err    (frame_err)
  );

  assign rx_byte       = core_byte;
  assign rx_byte_valid = core_valid;
  assign cmd_out       = cmd_out_q;
  assign cmd_valid     = cmd_valid_q;
  assign unknown_err   = unknown_err_q;
  assign overrun_err   = overrun_err_q;

  // Decode and handshake: a new command overrides any pending one; it only counts
  // as an overrun if the pending one was not being accepted in that same cycle.
  always_comb begin
    dec           = ascii_to_cmd(core_byte);
    hit           = core_valid & dec.valid;
    cmd_out_d     = hit ? dec.cmd : cmd_out_q;
    cmd_valid_d   = cmd_valid_q;
    if (hit) begin
      cmd_valid_d = 1'b1;
    end else if (cmd_valid_q && cmd_ready) begin
      cmd_valid_d = 1'b0;
    end
    unknown_err_d = core_valid & ~dec.valid;
    overrun_err_d = hit & cmd_valid_q & ~cmd_ready;
  end

  // Command output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_out_q     <= CMD_STOP;
      cmd_valid_q   <= 1'b0;
      unknown_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      cmd_out_q     <= cmd_out_d;
      cmd_valid_q   <= cmd_valid_d;
      unknown_err_q <= unknown_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Bench for uart_cmd_rx: directed scenarios followed by random frames, all checked
// against a byte-level model of the link (framing, command table, handshake).
module tb_uart_cmd_rx;

  localparam int CLKS = 8;
  localparam int SYNC = 2;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b1;
  logic       uart_in   = 1'b1;
  logic       cmd_ready = 1'b0;
  logic [2:0] cmd_out;
  logic       cmd_valid;
  logic [7:0] rx_byte;
  logic       rx_byte_valid;
  logic       frame_err;
  logic       unknown_err;
  logic       overrun_err;

  uart_cmd_rx #(
    .CLKS_PER_BIT(CLKS),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_in      (uart_in),
    .cmd_out      (cmd_out),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .rx_byte      (rx_byte),
    .rx_byte_valid(rx_byte_valid),
    .frame_err    (frame_err),
    .unknown_err  (unknown_err),
    .overrun_err  (overrun_err)
  );

  always #10 clk = ~clk;

  // Command table: the command code is the position of the character in this string.
  string cmdChars = "SFBLRH";

  // Observed pulse counts and timing of the DUT, sampled on the falling edge.
  int   cycleCount   = 0;
  int   rxvCount     = 0;
  int   ferrCount    = 0;
  int   unkCount     = 0;
  int   ovrCount     = 0;
  int   lastRxvCycle = 0;
  int   lastRise     = 0;
  logic prevValid    = 1'b0;

  always @(negedge clk) begin
    cycleCount++;
    if (rx_byte_valid) begin
      rxvCount++;
      lastRxvCycle = cycleCount;
    end
    if (frame_err)   ferrCount++;
    if (unknown_err) unkCount++;
    if (overrun_err) ovrCount++;
    if (cmd_valid && !prevValid) lastRise = cycleCount;
    prevValid = cmd_valid;
  end

  // Reference model state
  int         expRxv = 0, expFerr = 0, expUnk = 0, expOvr = 0;
  logic [2:0] mCmd     = 3'd0;
  bit         mValid   = 1'b0;
  logic [7:0] mRxByte  = 8'h00;

  int passCount  = 0;
  int checkCount = 0;

  function automatic void refLookup(input logic [7:0] b, output bit known, output logic [2:0] c);
    known = 1'b0;
    c     = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (cmdChars[i] == b) begin
        known = 1'b1;
        c     = 3'(i);
      end
    end
  endfunction

  task automatic modelFrame(input logic [7:0] b, input bit stopOk, input bit readyAtArrival);
    bit         known;
    logic [2:0] c;
    bit         accepted;
    if (!stopOk) begin
      expFerr++;
    end else begin
      expRxv++;
      mRxByte  = b;
      accepted = readyAtArrival && mValid;
      refLookup(b, known, c);
      if (known) begin
        if (mValid && !accepted) expOvr++;
        mCmd   = c;
        mValid = 1'b1;
      end else begin
        expUnk++;
        if (accepted) mValid = 1'b0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".cmd_out"},   32'(cmd_out),   32'(mCmd));
    checkOutput({tag, ".cmd_valid"}, 32'(cmd_valid), 32'(mValid));
    checkOutput({tag, ".rx_byte"},   32'(rx_byte),   32'(mRxByte));
    checkOutput({tag, ".rxv_cnt"},   32'(rxvCount),  32'(expRxv));
    checkOutput({tag, ".ferr_cnt"},  32'(ferrCount), 32'(expFerr));
    checkOutput({tag, ".unk_cnt"},   32'(unkCount),  32'(expUnk));
    checkOutput({tag, ".ovr_cnt"},   32'(ovrCount),  32'(expOvr));
  endtask

  // Drives one 8N1 frame starting at the current falling edge. abortBit >= 0 asserts
  // reset halfway through that data bit and returns with reset still held.
  task automatic applyStimulus(input logic [7:0] b, input bit stopBit, input int abortBit,
                               input bit readyOnArrival, output bit sawArrival);
    logic [9:0] frame;
    frame      = {stopBit, b, 1'b0};
    sawArrival = 1'b0;
    for (int i = 0; i < 10; i++) begin
      uart_in = frame[i];
      if (abortBit >= 0 && i == abortBit + 1) begin
        repeat (CLKS / 2) @(negedge clk);
        rst_n   = 1'b0;
        uart_in = 1'b1;
        return;
      end
      for (int k = 0; k < CLKS; k++) begin
        @(negedge clk);
        if (cmd_ready) begin
          cmd_ready = 1'b0;
        end else if (i == 9 && readyOnArrival && rx_byte_valid && !sawArrival) begin
          cmd_ready  = 1'b1;
          sawArrival = 1'b1;
        end
      end
    end
    if (cmd_ready) begin
      @(negedge clk);
      cmd_ready = 1'b0;
    end
  endtask

  task automatic sendAndModel(input logic [7:0] b, input bit stopBit, input bit rdy);
    bit saw;
    applyStimulus(b, stopBit, -1, rdy, saw);
    modelFrame(b, stopBit, rdy && stopBit);
  endtask

  task automatic idle(input int n);
    uart_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic acceptPulse(input string tag);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    mValid    = 1'b0;
    checkOutput({tag, ".accept_valid"}, 32'(cmd_valid), 32'(mValid));
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("[TB] FAIL watchdog: observed no completion within 60000 cycles, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw;
    #5 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;
    idle(100);
    checkAll("idle");

    $display("[TB] scenario 1: single 'F' and accept");
    sendAndModel(8'h46, 1'b1, 1'b0);
    idle(4);
    checkAll("t1_F");
    checkOutput("t1_latency", 32'(lastRise - lastRxvCycle), 32'd1);
    acceptPulse("t1");

    $display("[TB] scenario 2: 'L' then 'R' without accept");
    sendAndModel(8'h4C, 1'b1, 1'b0);
    sendAndModel(8'h52, 1'b1, 1'b0);
    idle(4);
    checkAll("t2_LR");

    $display("[TB] scenario 3: unknown byte 'A'");
    sendAndModel(8'h41, 1'b1, 1'b0);
    idle(4);
    checkAll("t3_A");

    $display("[TB] scenario 4: bad stop bit, line break, then 'S'");
    sendAndModel(8'h53, 1'b0, 1'b0);
    uart_in = 1'b0;
    repeat (40) @(negedge clk);
    idle(3 * CLKS);
    checkAll("t4_break");
    sendAndModel(8'h53, 1'b1, 1'b0);
    idle(4);
    checkAll("t4_S");

    $display("[TB] scenario 5: short glitch then 'B'");
    uart_in = 1'b0;
    repeat (2) @(negedge clk);
    idle(3 * CLKS);
    checkAll("t5_glitch");
    sendAndModel(8'h42, 1'b1, 1'b0);
    idle(4);
    checkAll("t5_B");

    $display("[TB] scenario 6: reset mid-frame, resend, accept on arrival");
    applyStimulus(8'h48, 1'b1, 4, 1'b0, saw);
    @(negedge clk);
    mCmd    = 3'd0;
    mValid  = 1'b0;
    mRxByte = 8'h00;
    checkAll("t6_in_reset");
    rst_n = 1'b1;
    idle(20);
    checkAll("t6_after_reset");
    sendAndModel(8'h48, 1'b1, 1'b0);
    idle(4);
    checkAll("t6_H");
    sendAndModel(8'h46, 1'b1, 1'b1);
    idle(4);
    checkAll("t6_ready_same_cycle");

    $display("[TB] random frames");
    for (int n = 0; n < 16; n++) begin
      logic [7:0] b;
      bit         stopOk;
      bit         rdy;
      if ($urandom_range(0, 1) == 1) b = cmdChars[$urandom_range(0, 5)];
      else b = 8'($urandom);
      stopOk = ($urandom_range(0, 5) != 0);
      rdy    = stopOk && ($urandom_range(0, 3) == 0);
      sendAndModel(b, stopOk, rdy);
      if (!stopOk) begin
        uart_in = 1'b0;
        repeat ($urandom_range(4, 30)) @(negedge clk);
      end
      idle(2 * CLKS);
      checkAll($sformatf("rand%0d", n));
      if ($urandom_range(0, 2) == 0) acceptPulse($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Base-station receiver for the drive-command link. It deserialises 8N1 UART frames arriving on a GPIO pin and decodes the single-byte ASCII commands into 3-bit drive commands. It presents each command on a valid/ready handshake to the base's motor logic. It is the far-end counterpart of the robot's command_translator + uart_tx chain and shares its command/ASCII map.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); must be >= 4.
SYNC_STAGES, 2, flip-flops in the uart_in synchroniser; must be >= 2.

Ports:
clk  input  1  system clock, 50 MHz.
rst_n  input  1  reset, asynchronous assert, active-low.
uart_in  input  1  serial line, idle high.
cmd_out  output  3  decoded drive command (cmd_t).
cmd_valid  output  1  cmd_out holds an unconsumed command.
cmd_ready  input  1  consumer accepts cmd_out when high with cmd_valid.
rx_byte  output  8  last correctly framed byte (raw, for debug/LCD).
rx_byte_valid  output  1  1-cycle pulse when rx_byte updates.
frame_err  output  1  1-cycle pulse when stop bit is sampled low.
unknown_err  output  1  1-cycle pulse when a framed byte is not in the command map.
overrun_err  output  1  1-cycle pulse when a pending command is overwritten.

Behaviour:
- Reset (async, rst_n=0): all outputs 0. cmd_out=CMD_STOP (3'd0). FSM in IDLE. Synchroniser flops preset to 1. Counters cleared. rst_n low mid-frame discards the partial byte; after release, the FSM waits for the line to be high before it arms.
- Synchroniser: uart_in passes through SYNC_STAGES flops. Only the synchronised signal rx_s is used.
- RX FSM states:
  - IDLE: a 1->0 transition on rx_s starts the bit counter and moves to START.
  - START: at count CLKS_PER_BIT/2 (integer divide), sample rx_s. If it is 1, treat as a glitch and return to IDLE with no error. If it is 0, clear the counter and go to DATA.
  - DATA: sample rx_s every CLKS_PER_BIT cycles into shift[bit_idx], LSB first, for bit_idx 0..7. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: load rx_byte and pulse rx_byte_valid on the next cycle, then go to IDLE.
    - If 0: pulse frame_err, leave rx_byte unchanged, go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This blocks false starts during a line break.
- Latency: rx_byte_valid rises 1 clk after the stop-bit sample. The decode is registered, so cmd_valid/unknown_err rises 1 clk after rx_byte_valid.
- Decode map (from the shared package):
  - 'S'(8'h53) -> 0 STOP
  - 'F'(8'h46) -> 1 FWD
  - 'B'(8'h42) -> 2 BACK
  - 'L'(8'h4C) -> 3 LEFT
  - 'R'(8'h52) -> 4 RIGHT
  - 'H'(8'h48) -> 5 HORN
  - Any other byte: pulse unknown_err; cmd_out and cmd_valid unchanged.
  - Lower-case is not accepted.
- Handshake: a transfer occurs on a cycle where cmd_valid && cmd_ready; cmd_valid drops the next cycle. While cmd_valid is high, cmd_out is stable unless overwritten.
- Overwrite: a new decoded command arriving while cmd_valid=1 and cmd_ready=0 replaces cmd_out, keeps cmd_valid=1 and pulses overrun_err. Newest command wins (motor safety).
- Simultaneous accept + new command in the same cycle: the new command loads, cmd_valid stays 1, and there is no overrun_err.
- Counters: the bit counter width is $clog2(CLKS_PER_BIT). Counters never wrap mid-bit; they are cleared at every state change.

Decomposition:
- Package matador_cmd_pkg:
  - typedef enum logic [2:0] cmd_t {CMD_STOP, CMD_FWD, CMD_BACK, CMD_LEFT, CMD_RIGHT, CMD_HORN}.
  - ASCII localparams ASC_STOP..ASC_HORN.
  - Functions cmd_to_ascii() and ascii_to_cmd() (the latter returns a valid flag).
  - command_translator is refactored to use this package too.
- Sub-module uart_rx_core (synchroniser + RX FSM; outputs rx_byte/rx_byte_valid/frame_err). uart_cmd_rx wraps it with the decode/handshake register.

Test Plan:
1. Reset release, line idle high for 100 clk: all outputs 0 and cmd_out=0. Then send 'F' (CLKS_PER_BIT=8) -> rx_byte=8'h46, rx_byte_valid pulse, next cycle cmd_out=1 and cmd_valid=1. cmd_ready=1 -> cmd_valid=0 the following cycle.
2. Send 'L' then 'R' back-to-back with cmd_ready=0 -> after 'R': cmd_out=4, cmd_valid=1, exactly one overrun_err pulse.
3. Send 8'h41 ('A') -> rx_byte=8'h41, unknown_err pulse, cmd_valid and cmd_out unchanged.
4. Send frame with stop bit=0 (data 8'h53), then hold line low 40 clk, release, then send 'S' -> one frame_err pulse, no rx_byte_valid for the bad frame; 'S' then decodes to cmd_out=0 with cmd_valid=1.
5. 2-clk low glitch on an idle line -> no rx_byte_valid, frame_err or unknown_err; the following 'B' decodes to 2.
6. Assert rst_n=0 during data bit 4 of 'H', release, send 'H' -> no output from the partial frame; second frame gives cmd_out=5. Also assert cmd_ready at the same cycle a new command arrives -> cmd_valid stays 1, no overrun_err.
